// File: rtl/btn_debounce_pulse_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ARMING    = 2'b01,
    ST_HELD      = 2'b10,
    ST_DISARMING = 2'b11
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_ACTIVE_LOW      = 1;
  localparam int DEF_REPEAT_EN       = 0;
  localparam int DEF_REPEAT_DELAY    = 50;
  localparam int DEF_REPEAT_PERIOD   = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_timer.sv
// Loadable, saturating up-counter with synchronous clear and a target-match flag.
module debounce_timer #(
  parameter int WIDTH = 3,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic [WIDTH-1:0] target,
  output logic             hit
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX);

  logic [WIDTH-1:0] count;

  // Count register: clear wins over load, load over increment; never passes LIMIT.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val > LIMIT) ? LIMIT : load_val;
    end else if (inc && (count != LIMIT)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign hit = (count == target);

endmodule

// File: rtl/btn_debounce_pulse.sv
// Raw push-button conditioner: synchroniser, debounce FSM, one-shot press pulse
// and optional auto-repeat pulses while the button is held.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int REPEAT_EN       = DEF_REPEAT_EN,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic pulse,
  output logic repeat_active
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic          RELEASED    = (ACTIVE_LOW != 0);
  localparam logic          REP         = (REPEAT_EN != 0);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1, sync2, btn_s;
  state_t        state, state_n;
  logic          cnt_clr, cnt_ld, cnt_inc, cnt_hit;
  logic          rpt_clr, rpt_inc, rpt_hit, rpt_step;
  logic [RW-1:0] rpt_target;
  logic          level_n, pulse_n, ract_n;

  // Two-flop synchroniser, both stages resetting to the released pin level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign btn_s      = sync2 ^ RELEASED;
  assign rpt_target = repeat_active ? PERIOD_LAST : DELAY_LAST;

  debounce_timer #(
    .WIDTH (CW),
    .MAX   (DEBOUNCE_CYCLES - 1)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clr),
    .load     (cnt_ld),
    .load_val (CW'(1)),
    .inc      (cnt_inc),
    .target   (CNT_LAST),
    .hit      (cnt_hit)
  );

  debounce_timer #(
    .WIDTH (RW),
    .MAX   (RMAX)
  ) u_rpt (
    .clk      (clk),
    .reset    (reset),
    .clear    (rpt_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (rpt_inc),
    .target   (rpt_target),
    .hit      (rpt_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state, timer controls and next output values.
  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_inc  = 1'b0;
    rpt_clr  = 1'b0;
    rpt_inc  = 1'b0;
    rpt_step = 1'b0;
    level_n  = btn_level;
    pulse_n  = 1'b0;
    ract_n   = repeat_active;
    case (state)
      ST_IDLE: begin
        if (btn_s) begin
          state_n = ST_ARMING;
          cnt_ld  = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      ST_ARMING: begin
        if (!btn_s) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_hit) begin
          state_n = ST_HELD;
          cnt_clr = 1'b1;
          rpt_clr = 1'b1;
          level_n = 1'b1;
          pulse_n = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_n = ST_DISARMING;
          cnt_ld  = 1'b1;
        end else begin
          rpt_step = 1'b1;
        end
      end
      ST_DISARMING: begin
        if (btn_s) begin
          state_n  = ST_HELD;
          cnt_clr  = 1'b1;
          rpt_step = 1'b1;
        end else if (cnt_hit) begin
          state_n = ST_IDLE;
          cnt_clr = 1'b1;
          rpt_clr = 1'b1;
          level_n = 1'b0;
          ract_n  = 1'b0;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_clr = 1'b1;
        rpt_clr = 1'b1;
        level_n = 1'b0;
        ract_n  = 1'b0;
      end
    endcase
    // rpt advances only on pressed samples while the level is accepted, so a
    // release bounce neither resets it nor fires on the exit edge.
    if (rpt_step) begin
      if (!REP) begin
        rpt_clr = 1'b1;
      end else if (rpt_hit) begin
        rpt_clr = 1'b1;
        ract_n  = 1'b1;
        pulse_n = !pulse;
      end else begin
        rpt_inc = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level     <= 1'b0;
      pulse         <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      btn_level     <= level_n;
      pulse         <= pulse_n;
      repeat_active <= ract_n;
    end
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench: two instances (no repeat / repeat 8,3) share one button
// stimulus; a sliding-window reference model predicts every cycle's outputs.
module tb_btn_debounce_pulse;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_raw = 1'b1;
  logic lvl_a, pul_a, ra_a;
  logic lvl_b, pul_b, ra_b;

  always #5 clk = ~clk;

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1),
    .REPEAT_EN       (0)
  ) dut_a (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_level     (lvl_a),
    .pulse         (pul_a),
    .repeat_active (ra_a)
  );

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (D),
    .ACTIVE_LOW      (1),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .btn_level     (lvl_b),
    .pulse         (pul_b),
    .repeat_active (ra_b)
  );

  typedef struct packed {
    logic lvl;
    logic pul;
    logic ra;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pulses_a    = 0;

  // Reference model state: raw-pin delay line, window of pressed samples,
  // accepted level, and count of pressed samples since acceptance.
  logic sq[$];
  logic hist[$];
  logic m_lvl = 1'b0;
  logic m_pa  = 1'b0;
  logic m_pb  = 1'b0;
  logic m_rb  = 1'b0;
  int   m_h   = 0;

  function automatic bit window_all(input logic v);
    if (hist.size() != D) return 1'b0;
    foreach (hist[i]) if (hist[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic raw, input logic rst);
    logic s;
    if (rst) begin
      sq.delete();
      sq.push_back(1'b1);
      sq.push_back(1'b1);
      hist.delete();
      m_lvl = 1'b0;
      m_pa  = 1'b0;
      m_pb  = 1'b0;
      m_rb  = 1'b0;
      m_h   = 0;
    end else begin
      s = ~sq.pop_front();
      sq.push_back(raw);
      hist.push_back(s);
      if (hist.size() > D) void'(hist.pop_front());
      m_pa = 1'b0;
      m_pb = 1'b0;
      if (!m_lvl) begin
        if (window_all(1'b1)) begin
          m_lvl = 1'b1;
          m_pa  = 1'b1;
          m_pb  = 1'b1;
          m_h   = 0;
        end
      end else if (window_all(1'b0)) begin
        m_lvl = 1'b0;
        m_rb  = 1'b0;
      end else if (s) begin
        m_h++;
        if (m_h == RD || (m_h > RD && (m_h - RD) % RP == 0)) begin
          m_pb = 1'b1;
          m_rb = 1'b1;
        end
      end
    end
    qa.push_back('{lvl: m_lvl, pul: m_pa, ra: 1'b0});
    qb.push_back('{lvl: m_lvl, pul: m_pb, ra: m_rb});
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the clock edge.
  logic prev_pa = 1'b0;
  logic prev_pb = 1'b0;
  always @(negedge clk) begin
    exp_t ea, eb;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      check("a.btn_level", lvl_a, ea.lvl);
      check("a.pulse", pul_a, ea.pul);
      check("a.repeat_active", ra_a, ea.ra);
      check("b.btn_level", lvl_b, eb.lvl);
      check("b.pulse", pul_b, eb.pul);
      check("b.repeat_active", ra_b, eb.ra);
      check("a.no_double_pulse", pul_a && prev_pa, 1'b0);
      check("b.no_double_pulse", pul_b && prev_pb, 1'b0);
      if (pul_a === 1'b1) pulses_a++;
      prev_pa = pul_a;
      prev_pb = pul_b;
    end
  end

  task automatic step(input logic raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    #1;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  initial begin
    int base;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 5);
    // clean press and release
    hold(1'b0, 12);
    hold(1'b1, 12);
    // short glitch, rejected
    hold(1'b0, 3);
    hold(1'b1, 10);
    // long hold (repeat pulses on dut_b), bouncy release
    hold(1'b0, 30);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 12);
    // reset two cycles into arming, then a full new debounce
    hold(1'b0, 4);
    step(1'b0, 1'b1);
    hold(1'b0, 10);
    hold(1'b1, 12);
    // eight clean presses give eight pulses on dut_a
    base = pulses_a;
    for (int p = 0; p < 8; p++) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (pulses_a - base != 8) begin
      miscompares++;
      $display("FAIL press_count: got %0d expected 8", pulses_a - base);
    end
    // random runs of varying length with occasional resets
    for (int r = 0; r < 80; r++) begin
      logic lv;
      int   len;
      lv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 30) == 0) step(lv, 1'b1);
      hold(lv, len);
    end
    hold(1'b1, 12);
    @(negedge clk);
    #1;
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", qa.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
